// File: rtl/md_cell_pkg.sv
// Constants shared by the velocity cell memory clients and the reader FSM state encoding.
package md_cell_pkg;
  localparam int VEL_DATA_WIDTH    = 96;
  localparam int CELL_ADDR_WIDTH   = 8;
  localparam int CELL_PARTICLE_NUM = 220;
  localparam int CELL_COUNT_ADDR   = 0;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    DONE
  } reader_state_t;
endpackage

// File: rtl/vel_skid_fifo2.sv
// Two-entry skid FIFO holding read records until the consumer takes them.
module vel_skid_fifo2 #(
  parameter int WIDTH = 104
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occupancy;

  // A push while full is only ever paired with a pop, so the overwritten slot is the one leaving.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (occupancy == 2'd2);
  assign empty     = (occupancy == 2'd0);
endmodule

// File: rtl/velocity_cell_reader.sv
// Reads the particle count from a velocity cell RAM, then streams records 1..count over valid/ready.
// Optional VELOCITY_READER_COUNT_CHECK_EN clamps oversized counts and raises a sticky count_err.
module velocity_cell_reader
  import md_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = VEL_DATA_WIDTH,
  parameter int PARTICLE_NUM = CELL_PARTICLE_NUM,
  parameter int ADDR_WIDTH   = CELL_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
`ifdef VELOCITY_READER_COUNT_CHECK_EN
  output logic                  count_err,
`endif
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);
  localparam int FIFO_W = DATA_WIDTH + ADDR_WIDTH;

  if (PARTICLE_NUM > (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("velocity_cell_reader: PARTICLE_NUM exceeds the address space");
  end

  reader_state_t         state;
  logic [ADDR_WIDTH:0]   rp;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] pid_p1;
  logic [ADDR_WIDTH-1:0] cnt_raw_p0;
  logic [ADDR_WIDTH-1:0] cnt_use_p0;
  logic [FIFO_W-1:0]     head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  credit_ok;
  logic                  issue;

`ifdef VELOCITY_READER_COUNT_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  function automatic logic [ADDR_WIDTH-1:0] sat_count(input logic [ADDR_WIDTH-1:0] raw);
    return (raw > MAX_COUNT) ? MAX_COUNT : raw;
  endfunction
`endif

  assign cnt_raw_p0 = mem_q[ADDR_WIDTH-1:0];
`ifdef VELOCITY_READER_COUNT_CHECK_EN
  assign cnt_use_p0 = sat_count(cnt_raw_p0);
`else
  assign cnt_use_p0 = cnt_raw_p0;
`endif

  assign mem_wren  = 1'b0;
  assign mem_data  = '0;
  assign out_valid = ~fifo_empty;
  assign {out_pid, out_data} = head;
  assign out_last  = out_valid & (out_pid == particle_count);
  assign pop       = out_valid & out_ready;

  // Credit: entries held, minus the one leaving now, plus the read in flight must leave room for one more.
  assign credit_ok = fifo_empty | (~fifo_full & ~vld_p1) | (pop & ~(fifo_full & vld_p1));
  assign issue     = (state == STREAM) & credit_ok;
  assign mem_rden  = (state == RD_CNT) | issue;
  assign mem_address = (state == STREAM) ? rp[ADDR_WIDTH-1:0] : ADDR_WIDTH'(CELL_COUNT_ADDR);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      particle_count <= '0;
      rp             <= '0;
      vld_p1         <= 1'b0;
`ifdef VELOCITY_READER_COUNT_CHECK_EN
      count_err      <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      vld_p1 <= issue;
      if (issue) rp <= rp + {{ADDR_WIDTH{1'b0}}, 1'b1};
      case (state)
        IDLE: begin
          if (start) begin
            state <= RD_CNT;
            busy  <= 1'b1;
`ifdef VELOCITY_READER_COUNT_CHECK_EN
            count_err <= 1'b0;
`endif
          end
        end
        RD_CNT: state <= WAIT_CNT;
        WAIT_CNT: begin
          particle_count <= cnt_use_p0;
          rp             <= {{ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef VELOCITY_READER_COUNT_CHECK_EN
          if (cnt_raw_p0 > MAX_COUNT) count_err <= 1'b1;
`endif
          if (cnt_use_p0 == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= STREAM;
          end
        end
        STREAM: if (issue && (rp == {1'b0, particle_count})) state <= DRAIN;
        DRAIN: begin
          if (pop && out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: RAM data on mem_q, tagged with the address it was read from.
  always_ff @(posedge clock) begin
    if (issue) pid_p1 <= rp[ADDR_WIDTH-1:0];
  end

  vel_skid_fifo2 #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clock    (clock),
    .rst      (rst),
    .push     (vld_p1),
    .pop      (pop),
    .push_data({pid_p1, mem_q}),
    .head_data(head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule
